branch_resolve_unit: RTL and testbench

// - EX-stage companion of the BTB. Carries each fetch's BTB prediction (hit, predicted PC) through the IF/ID and ID/EX slots.
// - In EX, compares the prediction with the resolved branch outcome. On a mispredict, raises a same-cycle redirect.
// - One cycle later, drives the BTB update port (BTBflush, BrNPC, EXpc) and keeps branch/mispredict statistics.

---
 rtl/branch_resolve_unit_if.sv | 33 +++
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the fetch/EX pipeline and branch_resolve_unit.
// master = pipeline side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             flush_id;
    logic             if_btb_hit;
    logic [31:0]      if_pre_pc;
    logic             ex_is_br;
    logic             ex_taken;
    logic [31:0]      ex_br_npc;
    logic [31:0]      ex_pc;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [1:0]       BTBflush;
    logic [31:0]      BrNPC;
    logic [31:0]      EXpc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output stall, flush_id, if_btb_hit, if_pre_pc,
        output ex_is_br, ex_taken, ex_br_npc, ex_pc,
        input  redirect, redirect_pc, BTBflush, BrNPC, EXpc, br_cnt, miss_cnt
    );

    modport slave (
        input  stall, flush_id, if_btb_hit, if_pre_pc,
        input  ex_is_br, ex_taken, ex_br_npc, ex_pc,
        output redirect, redirect_pc, BTBflush, BrNPC, EXpc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries BTB predictions to EX, redirects fetch on a
// mispredict, then issues a one-cycle BTB update. Define BHT_EN to gate updates with a 2-bit BHT.
module branch_resolve_unit #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    branch_resolve_unit_if.slave bus
);

    typedef struct packed {
        logic        v;
        logic        hit;
        logic [31:0] ppc;
    } slot_t;

    typedef enum logic [1:0] {
        UPD_IDLE  = 2'b00,
        UPD_INVAL = 2'b01,
        UPD_WRITE = 2'b10
    } upd_e;

    localparam slot_t BUBBLE = slot_t'{v: 1'b0, hit: 1'b0, ppc: 32'd0};

    if (IDX_W < 1 || IDX_W > 30) begin : g_bad_idx_w
        $error("branch_resolve_unit: IDX_W must be in 1..30");
    end

    slot_t            id_q, ex_q;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      pc_plus4;
    logic             ex_live_br;
    upd_e             upd_raw, upd;
    upd_e             flush_q;
    logic [31:0]      br_npc_q, ex_pc_q;
    logic [CNT_W-1:0] br_cnt_q, miss_cnt_q;

    assign pc_plus4   = bus.ex_pc + 32'd4;
    assign ex_live_br = ex_q.v & bus.ex_is_br;

    // Mispredict = predicted direction differs from actual, or both taken with a stale target.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        redirect    = 1'b0;
        redirect_pc = '0;
        upd_raw     = UPD_IDLE;
        if (ex_q.v) begin
            if (bus.ex_is_br && bus.ex_taken) begin
                if (!ex_q.hit || (ex_q.ppc != bus.ex_br_npc)) begin
                    redirect    = 1'b1;
                    redirect_pc = bus.ex_br_npc;
                    upd_raw     = UPD_WRITE;
                end
            end else if (ex_q.hit) begin
                redirect    = 1'b1;
                redirect_pc = pc_plus4;
                upd_raw     = UPD_INVAL;
            end
        end
    end

`ifdef BHT_EN
    localparam int BHT_N = 2 ** IDX_W;

    logic [1:0]       bht_q [BHT_N];
    logic [IDX_W-1:0] bht_idx;
    logic [1:0]       bht_cur, bht_next;

    assign bht_idx = bus.ex_pc[IDX_W+1:2];
    assign bht_cur = bht_q[bht_idx];

    // Writes need a strong/weak-taken counter, branch invalidates need not-taken; aliases pass through.
    always_comb begin
        bht_next = bht_cur;
        if (bus.ex_taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
        end else if (bht_cur != 2'b00) begin
            bht_next = bht_cur - 2'd1;
        end
        upd = upd_raw;
        if (ex_live_br) begin
            if (upd_raw == UPD_WRITE && !bht_next[1]) upd = UPD_IDLE;
            if (upd_raw == UPD_INVAL &&  bht_next[1]) upd = UPD_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is built from flops so reset can clear it; a RAM macro could not be reset.
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (ex_live_br) begin
            bht_q[bht_idx] <= bht_next;
        end
    end
`else
    assign upd = upd_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            id_q <= BUBBLE;
            ex_q <= BUBBLE;
        end else if (redirect) begin
            id_q <= BUBBLE;
            ex_q <= BUBBLE;
        end else if (bus.stall) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= id_q;
            id_q <= slot_t'{v:   ~bus.flush_id,
                            hit: bus.if_btb_hit & ~bus.flush_id,
                            ppc: bus.if_pre_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q    <= UPD_IDLE;
            br_npc_q   <= '0;
            ex_pc_q    <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            flush_q <= upd;
            if (upd != UPD_IDLE) begin
                br_npc_q <= bus.ex_br_npc;
                ex_pc_q  <= bus.ex_pc;
            end
            if (ex_live_br && (br_cnt_q != '1))  br_cnt_q   <= br_cnt_q + CNT_W'(1);
            if (redirect && (miss_cnt_q != '1))  miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;
    assign bus.BTBflush    = flush_q;
    assign bus.BrNPC       = br_npc_q;
    assign bus.EXpc        = ex_pc_q;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases, randomized traffic and mid-run reset.
// Narrow counters (CNT_W=4) exercise saturation; the BHT_EN build is covered by the same model.
module tb_branch_resolve_unit;

    localparam int CNT_W   = 4;
    localparam int IDX_W   = 4;
    localparam int CNT_MAX = 15;
`ifdef BHT_EN
    localparam logic [31:0] NT_FLUSH = 32'h0;
`else
    localparam logic [31:0] NT_FLUSH = 32'h1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();
    branch_resolve_unit #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        redirect;
        bit [31:0] rpc;
        bit [1:0]  flush;
        bit [31:0] npc;
        bit [31:0] expc;
        int        br;
        int        miss;
    } exp_t;

    typedef struct {
        bit        v;
        bit        hit;
        bit [31:0] ppc;
    } pred_t;

    exp_t      sb[$];
    int        pushed = 0;
    int        popped = 0;

    // Reference state: predictions in flight, pending BTB update, statistics, BHT.
    pred_t     m_id, m_ex;
    bit [1:0]  m_flush;
    bit [31:0] m_npc, m_expc;
    int        m_br, m_miss;
    int        m_bht[2**IDX_W];

    function automatic void model_reset();
        m_id    = '{v: 0, hit: 0, ppc: 0};
        m_ex    = '{v: 0, hit: 0, ppc: 0};
        m_flush = 2'b00;
        m_npc   = 0;
        m_expc  = 0;
        m_br    = 0;
        m_miss  = 0;
        foreach (m_bht[i]) m_bht[i] = 1;
    endfunction

    // One clock of stimulus; the expected outputs for that cycle go to the scoreboard.
    task automatic cycle(input bit st, input bit fl, input bit hit, input bit [31:0] ppc,
                         input bit br, input bit tk, input bit [31:0] npc, input bit [31:0] pc);
        exp_t      e;
        bit        actual_taken, pred_taken, r;
        bit [31:0] rpc;
        bit [1:0]  upd;
        int        idx, nc;
        @(posedge clk);
        #1;
        bus.stall      = st;
        bus.flush_id   = fl;
        bus.if_btb_hit = hit;
        bus.if_pre_pc  = ppc;
        bus.ex_is_br   = br;
        bus.ex_taken   = tk;
        bus.ex_br_npc  = npc;
        bus.ex_pc      = pc;

        actual_taken = br && tk;
        pred_taken   = m_ex.hit;
        r   = 0;
        rpc = 0;
        upd = 2'b00;
        idx = 0;
        nc  = 0;
        if (m_ex.v) begin
            r = (pred_taken != actual_taken) || (actual_taken && m_ex.ppc != npc);
            if (r) begin
                rpc = actual_taken ? npc : pc + 32'd4;
                upd = actual_taken ? 2'b10 : 2'b01;
            end
`ifdef BHT_EN
            if (br) begin
                idx = int'(pc[IDX_W+1:2]);
                nc  = m_bht[idx] + (tk ? 1 : -1);
                if (nc > 3) nc = 3;
                if (nc < 0) nc = 0;
                if (upd == 2'b10 && nc < 2) upd = 2'b00;
                if (upd == 2'b01 && nc > 1) upd = 2'b00;
                m_bht[idx] = nc;
            end
`endif
        end

        e = '{redirect: r, rpc: rpc, flush: m_flush, npc: m_npc, expc: m_expc,
              br: m_br, miss: m_miss};
        sb.push_back(e);
        pushed++;

        m_flush = upd;
        if (upd != 2'b00) begin
            m_npc  = npc;
            m_expc = pc;
        end
        if (m_ex.v && br && m_br < CNT_MAX) m_br++;
        if (r && m_miss < CNT_MAX) m_miss++;
        if (r) begin
            m_id = '{v: 0, hit: 0, ppc: 0};
            m_ex = '{v: 0, hit: 0, ppc: 0};
        end else if (st) begin
            m_ex = '{v: 0, hit: 0, ppc: 0};
        end else begin
            m_ex = m_id;
            m_id = '{v: !fl, hit: hit && !fl, ppc: ppc};
        end
    endtask

    task automatic idle();
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " redirect"},    bus.redirect,    0);
        check({tag, " redirect_pc"}, bus.redirect_pc, 0);
        check({tag, " BTBflush"},    bus.BTBflush,    0);
        check({tag, " BrNPC"},       bus.BrNPC,       0);
        check({tag, " EXpc"},        bus.EXpc,        0);
        check({tag, " br_cnt"},      bus.br_cnt,      0);
        check({tag, " miss_cnt"},    bus.miss_cnt,    0);
    endtask

    task automatic random_cycles(input int n);
        bit [31:0] pcs [4];
        bit [31:0] tgts[3];
        pcs  = '{32'h40, 32'h44, 32'h80, 32'hFFFF_FFFC};
        tgts = '{32'h80, 32'h90, 32'h44};
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                  1'($urandom_range(0, 1)), tgts[$urandom_range(0, 2)],
                  $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                  tgts[$urandom_range(0, 2)], pcs[$urandom_range(0, 3)]);
        end
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                if (rst_n) begin
                    check("redirect",    bus.redirect,    e.redirect);
                    check("redirect_pc", bus.redirect_pc, e.rpc);
                    check("BTBflush",    bus.BTBflush,    e.flush);
                    if (e.flush == 2'b10) check("BrNPC", bus.BrNPC, e.npc);
                    if (e.flush != 2'b00) check("EXpc",  bus.EXpc,  e.expc);
                    check("br_cnt",      bus.br_cnt,      e.br);
                    check("miss_cnt",    bus.miss_cnt,    e.miss);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stall = 0; bus.flush_id = 1; bus.if_btb_hit = 0; bus.if_pre_pc = 0;
        bus.ex_is_br = 0; bus.ex_taken = 0; bus.ex_br_npc = 0; bus.ex_pc = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_all_zero("por");
        #9 rst_n = 1'b1;

        idle(); idle();
        // Cold taken branch.
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        cycle(0, 1, 0, 0, 1, 1, 32'h80, 32'h40);
        #1 check("cold redirect", bus.redirect, 1);
        check("cold redirect_pc", bus.redirect_pc, 32'h80);
        idle();
        #1 check("cold BTBflush", bus.BTBflush, 2);
        check("cold BrNPC", bus.BrNPC, 32'h80);
        check("cold EXpc", bus.EXpc, 32'h40);
        idle();
        #1 check("cold BTBflush after", bus.BTBflush, 0);

        // Predicted-correct branch.
        cycle(0, 0, 1, 32'h80, 0, 0, 0, 0);
        idle();
        cycle(0, 1, 0, 0, 1, 1, 32'h80, 32'h40);
        #1 check("hit redirect", bus.redirect, 0);
        idle();
        #1 check("hit BTBflush", bus.BTBflush, 0);
        check("hit br_cnt", bus.br_cnt, 2);
        check("hit miss_cnt", bus.miss_cnt, 1);

        // Hit but not taken.
        cycle(0, 0, 1, 32'h80, 0, 0, 0, 0);
        idle();
        cycle(0, 1, 0, 0, 1, 0, 32'h80, 32'h40);
        #1 check("nt redirect", bus.redirect, 1);
        check("nt redirect_pc", bus.redirect_pc, 32'h44);
        idle();
        #1 check("nt BTBflush", bus.BTBflush, NT_FLUSH);
        check("nt EXpc", bus.EXpc, 32'h40);

        // Wrong target while stalled; younger ID entry must be killed.
        idle();
        cycle(0, 0, 1, 32'h80, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h80, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 1, 32'h90, 32'h40);
        #1 check("wt redirect", bus.redirect, 1);
        check("wt redirect_pc", bus.redirect_pc, 32'h90);
        cycle(0, 1, 0, 0, 1, 1, 32'h90, 32'h40);
        #1 check("wt bubble redirect", bus.redirect, 0);
        check("wt BTBflush", bus.BTBflush, 2);
        check("wt BrNPC", bus.BrNPC, 32'h90);
        cycle(0, 1, 0, 0, 1, 0, 0, 32'h40);
        #1 check("wt killed id redirect", bus.redirect, 0);

        random_cycles(800);

        // Reset mid-operation with an update pending.
        idle(); idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        cycle(0, 1, 0, 0, 1, 1, 32'h88, 32'h48);
        #1 check("pre-reset redirect", bus.redirect, 1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async reset");
        @(posedge clk);
        #1 check("reset no leak BTBflush", bus.BTBflush, 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

        random_cycles(200);

        @(negedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);
        check("monitor pops", popped, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
